mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_access_load_extend.sv | 26 ++
 rtl/mem_access.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and encodings for the MEM pipeline stage
package mem_access_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: is_misaligned = offset[0];
            F3_W:        is_misaligned = (offset != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// rtl/mem_access_load_extend.sv - selects and extends the loaded byte/half from a read word
module load_extend
    import mem_access_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'h0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'h0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: issues data-memory accesses and produces write-back results
module mem_access
    import mem_access_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      read_data2_i,
    input  logic [REGADDR_W-1:0] write_reg_i,
    input  logic                 reg_write_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    output logic [3:0]           dmem_be_o,
    input  logic                 dmem_ack_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic [REGADDR_W-1:0] write_reg_o,
    output logic                 reg_write_o,
    output logic                 misaligned_o
);

    state_e                 state_q;
    logic                   ready_q, valid_q, mis_q, rw_out_q;
    logic [XLEN-1:0]        wb_q;
    logic [REGADDR_W-1:0]   wr_reg_q;
    logic                   req_q, we_q;
    logic [XLEN-1:0]        addr_q, wdata_q;
    logic [3:0]             be_q;
    logic [1:0]             off_q;
    logic [2:0]             f3_q;
    logic                   load_rw_q;

    logic [1:0]             offset;
    logic                   mem_op;
    logic [3:0]             store_be;
    logic [XLEN-1:0]        store_wdata;
    logic [XLEN-1:0]        load_val;

    assign offset = alu_result_i[1:0];
    assign mem_op = mem_read_i | mem_write_i;

    // Loads request the whole word; lane selection happens on the way back.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = read_data2_i;
        if (mem_write_i) begin
            case (funct3_i)
                F3_B, F3_BU: begin
                    store_be    = 4'b0001 << offset;
                    store_wdata = {4{read_data2_i[7:0]}};
                end
                F3_H, F3_HU: begin
                    store_be    = 4'b0011 << offset;
                    store_wdata = {2{read_data2_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata_i  (dmem_rdata_i),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (load_val)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            rw_out_q  <= 1'b0;
            wb_q      <= '0;
            wr_reg_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            load_rw_q <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            rw_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_i && ready_q) begin
                        wr_reg_q <= write_reg_i;
                        if (!mem_op) begin
                            valid_q  <= 1'b1;
                            wb_q     <= alu_result_i;
                            rw_out_q <= reg_write_i;
                        end else if (is_misaligned(funct3_i, offset)) begin
                            valid_q <= 1'b1;
                            mis_q   <= 1'b1;
                            wb_q    <= alu_result_i;
                        end else begin
                            req_q     <= 1'b1;
                            we_q      <= mem_write_i;
                            addr_q    <= {alu_result_i[XLEN-1:2], 2'b00};
                            wdata_q   <= store_wdata;
                            be_q      <= store_be;
                            off_q     <= offset;
                            f3_q      <= funct3_i;
                            load_rw_q <= reg_write_i & mem_read_i;
                            ready_q   <= 1'b0;
                            state_q   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Request stays frozen until the memory acknowledges it.
                    if (dmem_ack_i) begin
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        valid_q  <= 1'b1;
                        wb_q     <= load_val;
                        rw_out_q <= load_rw_q;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = valid_q;
    assign misaligned_o = mis_q;
    assign reg_write_o  = rw_out_q;
    assign wb_data_o    = wb_q;
    assign write_reg_o  = wr_reg_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;

endmodule
